// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared sizes, FSM state type and one-hot helper for the round-robin mux arbiter.
package mux_arb_pkg;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    typedef enum logic {IDLE, GRANT} state_t;
    function automatic logic [N_REQ-1:0] onehot2(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction
endpackage

// File: rtl/rr_pick_4.sv
// rr_pick_4: combinational rotating-priority picker, scanning ptr+1, ptr+2, ptr+3, ptr.
module rr_pick_4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_REQ-1:0] mask,
    output logic             any,
    output logic [SEL_W-1:0] idx
);
    logic [N_REQ-1:0] w_req;
    assign w_req = req & ~mask;
    assign any = |w_req;
    // Walk from lowest to highest priority so the nearest requester after ptr wins.
    always_comb begin
        idx = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            logic [SEL_W-1:0] c;
            c = ptr + SEL_W'(k);
            if (w_req[c]) idx = c;
        end
    end
endmodule

// File: rtl/mux_rr_arbiter_4.sv
// mux_rr_arbiter_4: round-robin owner of a shared DW-wide 4:1 select path.
// Define MUX_ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD contended cycles.
module mux_rr_arbiter_4
    import mux_arb_pkg::*;
#(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
)(
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_REQ-1:0]    REQ,
    input  logic [N_REQ*DW-1:0] I,
    output logic [N_REQ-1:0]    GNT,
    output logic [SEL_W-1:0]    SEL,
    output logic [DW-1:0]       OUT,
    output logic                OUT_VALID,
    output logic                BUSY
);
    state_t           r_state, w_state_nx;
    logic [N_REQ-1:0] r_gnt, w_gnt_nx, w_mask;
    logic [SEL_W-1:0] r_sel, w_sel_nx, r_ptr, w_ptr_nx, w_idx;
    logic             r_busy, w_any, w_own, w_tmo, w_keep;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_hold_chk
        $error("MAX_HOLD must be in 1..255");
    end

    assign w_own = (r_state == GRANT) && REQ[r_sel];
`ifdef MUX_ARB_TIMEOUT_EN
    logic [7:0] r_hcnt, w_hcnt_nx;
    assign w_tmo = w_own && (r_hcnt >= 8'(MAX_HOLD - 1)) && |(REQ & ~onehot2(r_sel));
    assign w_hcnt_nx = !w_keep ? 8'd0 : (r_hcnt == 8'hFF) ? r_hcnt : r_hcnt + 8'd1;
`else
    assign w_tmo = 1'b0;
`endif
    // A preempted owner still requests, so it is masked out of the rotation pick.
    assign w_mask = w_tmo ? onehot2(r_sel) : '0;
    assign w_keep = w_own && !w_tmo;

    rr_pick_4 u_pick (
        .req  (REQ),
        .ptr  (r_ptr),
        .mask (w_mask),
        .any  (w_any),
        .idx  (w_idx)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= SEL_W'(N_REQ - 1);
            r_busy  <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            r_hcnt  <= 8'd0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_sel   <= w_sel_nx;
            r_ptr   <= w_ptr_nx;
            r_busy  <= (w_state_nx == GRANT);
`ifdef MUX_ARB_TIMEOUT_EN
            r_hcnt  <= w_hcnt_nx;
`endif
        end
    end

    always_comb begin
        w_state_nx = (w_keep || w_any) ? GRANT : IDLE;
        w_gnt_nx   = w_keep ? r_gnt : w_any ? onehot2(w_idx) : '0;
        w_sel_nx   = (w_keep || !w_any) ? r_sel : w_idx;
        w_ptr_nx   = (w_keep || !w_any) ? r_ptr : w_idx;
    end

    always_comb begin
        GNT       = r_gnt;
        SEL       = r_sel;
        BUSY      = r_busy;
        OUT_VALID = |r_gnt;
        OUT       = OUT_VALID ? I[r_sel*DW +: DW] : '0;
    end
endmodule

// File: tb/tb_mux_rr_arbiter_4.sv
// tb_mux_rr_arbiter_4: directed vectors with hand-computed grants for mux_rr_arbiter_4.
module tb_mux_rr_arbiter_4;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  REQ = 4'b0000;
    logic [31:0] I   = 32'hD4C3B2A5;
    logic [3:0]  GNT;
    logic [1:0]  SEL;
    logic [7:0]  OUT;
    logic        OUT_VALID, BUSY;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 CLK = ~CLK;

    mux_rr_arbiter_4 #(.DW(8), .MAX_HOLD(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .I         (I),
        .GNT       (GNT),
        .SEL       (SEL),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
        .BUSY      (BUSY)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        chk("onehot0", 32'($onehot0(GNT)), 32'd1);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] s, input logic [7:0] o);
        chk({tag, ".gnt"}, 32'(GNT), 32'(g));
        chk({tag, ".sel"}, 32'(SEL), 32'(s));
        chk({tag, ".out"}, 32'(OUT), 32'(o));
        chk({tag, ".vld"}, 32'(OUT_VALID), 32'(|g));
        chk({tag, ".busy"}, 32'(BUSY), 32'(|g));
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk_out("reset", 4'b0000, 2'd0, 8'h00);
        RST = 1'b0;
        tick();
        chk_out("idle", 4'b0000, 2'd0, 8'h00);
        // single requester, grant then release
        REQ = 4'b0001; tick(); chk_out("t1_gnt", 4'b0001, 2'd0, 8'hA5);
        REQ = 4'b0000; tick(); chk_out("t1_drop", 4'b0000, 2'd0, 8'h00);
        // all request, each owner leaves two cycles after its grant
        do_reset();
        REQ = 4'b1111; tick(); chk_out("t2_g0", 4'b0001, 2'd0, 8'hA5);
        tick();                chk_out("t2_h0", 4'b0001, 2'd0, 8'hA5);
        REQ = 4'b1110; tick(); chk_out("t2_g1", 4'b0010, 2'd1, 8'hB2);
        tick();                chk_out("t2_h1", 4'b0010, 2'd1, 8'hB2);
        REQ = 4'b1100; tick(); chk_out("t2_g2", 4'b0100, 2'd2, 8'hC3);
        tick();                chk_out("t2_h2", 4'b0100, 2'd2, 8'hC3);
        REQ = 4'b1000; tick(); chk_out("t2_g3", 4'b1000, 2'd3, 8'hD4);
        REQ = 4'b0000; tick(); chk_out("t2_idle", 4'b0000, 2'd3, 8'h00);
        // rotation wrap from owner 2
        do_reset();
        REQ = 4'b0100; tick(); chk_out("t3_g2", 4'b0100, 2'd2, 8'hC3);
        REQ = 4'b0000; tick(); chk_out("t3_idle", 4'b0000, 2'd2, 8'h00);
        REQ = 4'b0101; tick(); chk_out("t3_wrap", 4'b0001, 2'd0, 8'hA5);
        REQ = 4'b0100; tick(); chk_out("t3_sw2", 4'b0100, 2'd2, 8'hC3);
        REQ = 4'b1001; tick(); chk_out("t3_new3", 4'b1000, 2'd3, 8'hD4);
        REQ = 4'b1011; tick(); chk_out("t3_keep3", 4'b1000, 2'd3, 8'hD4);
        REQ = 4'b0011; tick(); chk_out("t3_g0", 4'b0001, 2'd0, 8'hA5);
        REQ = 4'b0010; tick(); chk_out("t3_g1", 4'b0010, 2'd1, 8'hB2);
        // reset overrides a live grant, then regrant
        do_reset();
        REQ = 4'b0100; tick(); chk_out("t4_g2", 4'b0100, 2'd2, 8'hC3);
        RST = 1'b1;    tick(); chk_out("t4_rst", 4'b0000, 2'd0, 8'h00);
        RST = 1'b0;    tick(); chk_out("t4_regrant", 4'b0100, 2'd2, 8'hC3);
        // two requesters held constant
        do_reset();
        REQ = 4'b0011;
`ifdef MUX_ARB_TIMEOUT_EN
        begin
            logic [3:0] seq [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                    4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
            for (int k = 0; k < 9; k++) begin
                tick();
                chk($sformatf("t5_rot%0d", k), 32'(GNT), 32'(seq[k]));
            end
        end
        do_reset();
        REQ = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("t6_solo%0d", k), 32'(GNT), 32'(4'b0001));
        end
`else
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("t5_nopre%0d", k), 32'(GNT), 32'(4'b0001));
        end
`endif
        REQ = 4'b0000; tick(); chk_out("end_idle", 4'b0000, 2'd0, 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mux_rr_arbiter_4.md
Name: mux_rr_arbiter_4

Overview:
- Round-robin scheduler that shares one DW-wide 4:1 select path among four requesters.
- Each cycle it decides which requester owns the path and drives the select code and one-hot grant.
- Presents the selected requester's data on OUT, qualified by OUT_VALID.
- Sits in front of any shared single-consumer resource (bus, register write port, serializer) fed by four sources.

Parameters:
- DW, 8, data width per requester and of OUT.
- MAX_HOLD, 4, maximum consecutive grant cycles under contention; used only when MUX_ARB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  4  request per requester; level-sensitive, held until the requester is done.
- I  input  4*DW  packed data; requester k occupies I[k*DW +: DW].
- GNT  output  4  registered one-hot grant; all-zero when idle.
- SEL  output  2  registered binary index of current owner; equals encode(GNT) when granted.
- OUT  output  DW  I slice indexed by SEL when OUT_VALID is 1, else 0; combinational from registered SEL.
- OUT_VALID  output  1  equals |GNT.
- BUSY  output  1  registered; 1 in state GRANT.

Behaviour:
- Reset (RST=1 at an edge) forces these values, overriding any in-flight grant:
  - state=IDLE, GNT=0, SEL=0, BUSY=0, OUT_VALID=0, OUT=0.
  - last-owner pointer PTR=3, so requester 0 has first priority.
  - hold counter HCNT=0.
- Pick function: first k with REQ[k]=1, scanning PTR+1, PTR+2, PTR+3, PTR (mod 4).
- State IDLE:
  - If REQ!=0, go to GRANT at the next edge.
  - On that edge: GNT=onehot(pick), SEL=pick, PTR=pick, HCNT=0.
  - Latency from REQ asserted to GNT: 1 cycle.
- State GRANT, owner REQ[SEL]=1: keep the grant; HCNT increments and saturates at 255.
- State GRANT, owner REQ[SEL]=0 with other requests present:
  - Switch directly to the next pick at the next edge, with no idle bubble.
  - The released owner is excluded from this pick because its REQ is already 0.
- State GRANT, REQ all zero: go to IDLE at the next edge; GNT=0; SEL holds its last value; OUT becomes 0.
- Simultaneous events:
  - A new request arriving in the same cycle the owner drops takes part in that cycle's pick.
  - Requests from non-owners while the owner holds are queued implicitly and serviced in rotation order.
- The owner never loses its grant while REQ[SEL]=1, except through the optional timeout.
- Grant invariant: at most one GNT bit is set, checked every cycle.

Optional Feature:
- MUX_ARB_TIMEOUT_EN defined:
  - When HCNT reaches MAX_HOLD-1 while REQ[SEL]=1 and another REQ bit is set, the grant rotates at the next edge to pick(REQ with owner masked), even though the owner still requests.
  - HCNT resets to 0 on every grant change.
  - If no other requester is present, the owner keeps the grant and HCNT saturates.
- MUX_ARB_TIMEOUT_EN undefined:
  - No preemption; HCNT and MAX_HOLD logic are absent from the netlist.
  - MAX_HOLD is ignored.

Decomposition:
- Shared package mux_arb_pkg holds:
  - N_REQ=4 and SEL_W=2.
  - State enum {IDLE, GRANT}.
  - A function onehot2 for the one-hot/binary conversions.
- One natural sub-module: rr_pick_4, a purely combinational rotating priority picker.
  - Inputs: req[3:0], ptr[1:0], mask[3:0].
  - Outputs: any, idx[1:0].
  - Instantiated once by the FSM.

Test Plan:
- Reset then REQ=4'b0001 with I[7:0]=8'hA5 -> after 1 cycle GNT=0001, SEL=0, OUT=A5, OUT_VALID=1; drop REQ -> next cycle GNT=0, OUT=0.
- REQ=4'b1111 held; each owner drops its bit 2 cycles after its grant -> grant order 0,1,2,3, with no idle cycle between owners.
- After owner 2 releases, REQ=4'b0101 -> next owner is 0, not 2 (rotation from PTR=2 wraps to 0).
- RST pulsed for 1 cycle while GNT=0100 -> GNT=0, BUSY=0, SEL=0 at the next edge; with REQ=0100 still held, regrant to 2 one cycle after RST deasserts.
- MUX_ARB_TIMEOUT_EN, MAX_HOLD=4, REQ=4'b0011 held constant -> owner sequence 0,0,0,0,1,1,1,1,0... (alternation every 4 cycles).
- Same build with only REQ=0001 held -> GNT stays 0001 indefinitely.
